// File: rtl/lpc_pkg.sv
// Shared LPC cycle decoder definitions: one-hot phase bit indices, cycle-type codes
// and a helper that builds a one-hot phase vector.
package lpc_pkg;

    localparam int STATE_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADR3  = 4'd2,
        ST_ADR2  = 4'd3,
        ST_ADR1  = 4'd4,
        ST_ADR0  = 4'd5,
        ST_WDL   = 4'd6,
        ST_WDH   = 4'd7,
        ST_HTAR0 = 4'd8,
        ST_HTAR1 = 4'd9,
        ST_SYNC  = 4'd10,
        ST_RDL   = 4'd11,
        ST_RDH   = 4'd12,
        ST_PTAR0 = 4'd13,
        ST_PTAR1 = 4'd14,
        ST_SWAIT = 4'd15
    } lpc_phase_e;

    localparam logic [3:0] CYC_IO_RD  = 4'h0;
    localparam logic [3:0] CYC_IO_WR  = 4'h2;
    localparam logic [3:0] START_CODE = 4'h0;

    function automatic logic [STATE_W-1:0] phaseBit(input lpc_phase_e p);
        phaseBit    = '0;
        phaseBit[p] = 1'b1;
    endfunction

endpackage

// File: rtl/lpc_cycle_decoder.sv
// LPC target front end: tracks I/O read/write cycles with a one-hot phase FSM and decodes a fixed I/O window.
// Optional LPC_SYNC_WAIT_EN inserts one SWAIT phase between HTAR1 and SYNC on reads.
module lpc_cycle_decoder
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int          WIN_BITS  = 8
) (
    input  logic                LpcClock,
    input  logic                PciReset,
    input  logic                LFRAME_n,
    input  logic [3:0]          LAD,
    output logic                Opcode,
    output logic [WIN_BITS-1:0] AddrReg,
    output logic                Hit,
    output logic [STATE_W-1:0]  State,
    output logic [7:0]          WrData,
    output logic                WrStb,
    output logic                RdStb
);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_nextState;
    logic                r_opcode;
    logic                r_hit;
    logic                r_wrStb;
    logic                r_rdStb;
    logic [WIN_BITS-1:0] r_addrReg;
    logic [7:0]          r_wrData;
    logic [11:0]         r_addrHi;
    logic [15:0]         w_fullAddr;
    logic                w_winHit;
    logic                w_ioCycle;
    logic                w_inAddr;
    logic                w_capAddr;
    logic                w_nextIdle;

    // The low nibble is still on LAD during ADR0, so the full address is assembled live for the compare.
    assign w_fullAddr = {r_addrHi, LAD};
    assign w_winHit   = (w_fullAddr[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);
    assign w_ioCycle  = (LAD == CYC_IO_RD) || (LAD == CYC_IO_WR);
    assign w_inAddr   = r_state[ST_ADR3] | r_state[ST_ADR2] | r_state[ST_ADR1];
    assign w_capAddr  = LFRAME_n && r_state[ST_ADR0] && w_winHit;
    assign w_nextIdle = w_nextState[ST_IDLE] | w_nextState[ST_START];

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            r_state <= phaseBit(ST_IDLE);
        end else begin
            r_state <= w_nextState;
        end
    end

    // An asserted LFRAME_n overrides every phase: a start code restarts, anything else aborts.
    always_comb begin
        w_nextState = '0;
        if (!LFRAME_n) begin
            if (LAD == START_CODE) begin
                w_nextState[ST_START] = 1'b1;
            end else begin
                w_nextState[ST_IDLE] = 1'b1;
            end
        end else begin
            case (1'b1)
                r_state[ST_START]: begin
                    if (w_ioCycle) begin
                        w_nextState[ST_ADR3] = 1'b1;
                    end else begin
                        w_nextState[ST_IDLE] = 1'b1;
                    end
                end
                r_state[ST_ADR3]:  w_nextState[ST_ADR2] = 1'b1;
                r_state[ST_ADR2]:  w_nextState[ST_ADR1] = 1'b1;
                r_state[ST_ADR1]:  w_nextState[ST_ADR0] = 1'b1;
                r_state[ST_ADR0]: begin
                    if (!w_winHit) begin
                        w_nextState[ST_IDLE] = 1'b1;
                    end else if (r_opcode) begin
                        w_nextState[ST_WDL] = 1'b1;
                    end else begin
                        w_nextState[ST_HTAR0] = 1'b1;
                    end
                end
                r_state[ST_WDL]:   w_nextState[ST_WDH]   = 1'b1;
                r_state[ST_WDH]:   w_nextState[ST_HTAR0] = 1'b1;
                r_state[ST_HTAR0]: w_nextState[ST_HTAR1] = 1'b1;
`ifdef LPC_SYNC_WAIT_EN
                r_state[ST_HTAR1]: begin
                    if (r_opcode) begin
                        w_nextState[ST_SYNC] = 1'b1;
                    end else begin
                        w_nextState[ST_SWAIT] = 1'b1;
                    end
                end
                r_state[ST_SWAIT]: w_nextState[ST_SYNC] = 1'b1;
`else
                r_state[ST_HTAR1]: w_nextState[ST_SYNC] = 1'b1;
`endif
                r_state[ST_SYNC]: begin
                    if (r_opcode) begin
                        w_nextState[ST_PTAR0] = 1'b1;
                    end else begin
                        w_nextState[ST_RDL] = 1'b1;
                    end
                end
                r_state[ST_RDL]:   w_nextState[ST_RDH]   = 1'b1;
                r_state[ST_RDH]:   w_nextState[ST_PTAR0] = 1'b1;
                r_state[ST_PTAR0]: w_nextState[ST_PTAR1] = 1'b1;
                default:           w_nextState[ST_IDLE]  = 1'b1;
            endcase
        end
    end

    // Strobes are decoded from the next phase so they line up exactly with SYNC / HTAR0 on State.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            r_opcode  <= 1'b0;
            r_hit     <= 1'b0;
            r_wrStb   <= 1'b0;
            r_rdStb   <= 1'b0;
            r_addrReg <= '0;
            r_wrData  <= 8'h00;
            r_addrHi  <= 12'h000;
        end else begin
            r_wrStb <= w_nextState[ST_SYNC] & r_opcode;
            r_rdStb <= w_nextState[ST_HTAR0] & ~r_opcode;
            if (r_state[ST_START] && LFRAME_n && w_ioCycle) begin
                r_opcode <= (LAD == CYC_IO_WR);
            end
            if (LFRAME_n && w_inAddr) begin
                r_addrHi <= {r_addrHi[7:0], LAD};
            end
            if (w_nextIdle) begin
                r_hit <= 1'b0;
            end else if (w_capAddr) begin
                r_hit <= 1'b1;
            end
            if (w_capAddr) begin
                r_addrReg <= w_fullAddr[WIN_BITS-1:0];
            end
            if (LFRAME_n && r_state[ST_WDL]) begin
                r_wrData[3:0] <= LAD;
            end
            if (LFRAME_n && r_state[ST_WDH]) begin
                r_wrData[7:4] <= LAD;
            end
        end
    end

    assign State   = r_state;
    assign Opcode  = r_opcode;
    assign Hit     = r_hit;
    assign AddrReg = r_addrReg;
    assign WrData  = r_wrData;
    assign WrStb   = r_wrStb;
    assign RdStb   = r_rdStb;

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Self-checking bench for lpc_cycle_decoder: directed LPC I/O cycles plus randomized cycles
// checked against a transaction-level phase model.
module tb_lpc_cycle_decoder;

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_ADR3  = 2;
    localparam int P_ADR2  = 3;
    localparam int P_ADR1  = 4;
    localparam int P_ADR0  = 5;
    localparam int P_WDL   = 6;
    localparam int P_WDH   = 7;
    localparam int P_HTAR0 = 8;
    localparam int P_HTAR1 = 9;
    localparam int P_SYNC  = 10;
    localparam int P_RDL   = 11;
    localparam int P_RDH   = 12;
    localparam int P_PTAR0 = 13;
    localparam int P_PTAR1 = 14;
    localparam int P_SWAIT = 15;

    logic        LpcClock = 1'b0;
    logic        PciReset;
    logic        LFRAME_n;
    logic [3:0]  LAD;
    logic        Opcode;
    logic [7:0]  AddrReg;
    logic        Hit;
    logic [15:0] State;
    logic [7:0]  WrData;
    logic        WrStb;
    logic        RdStb;

    int          assertCount = 0;
    int          failCount   = 0;
    logic        mdlOpcode;
    logic [7:0]  mdlAddr;
    logic [7:0]  mdlWrData;
    bit          endedInStart;

    lpc_cycle_decoder dut (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .LFRAME_n (LFRAME_n),
        .LAD      (LAD),
        .Opcode   (Opcode),
        .AddrReg  (AddrReg),
        .Hit      (Hit),
        .State    (State),
        .WrData   (WrData),
        .WrStb    (WrStb),
        .RdStb    (RdStb)
    );

    always #15 LpcClock = ~LpcClock;

    // Builds the host nibble stream and the expected phase sequence for one cycle, then drives it
    // and compares every clock.
    task automatic runTxn(input logic [3:0] cyc, input logic [15:0] addr, input logic [7:0] data,
                          input int startLen, input int abortAt, input logic [3:0] abortLad,
                          input int stopAt, input string tag);
        int         ph[$];
        logic [4:0] nib[$];
        bit         isWr;
        bit         valid;
        bit         hit;
        bit         live;
        int         s;
        int         n;
        int         abortIdx;
        logic [15:0] expState;
        logic        expHit;
        logic        expWr;
        logic        expRd;
        s     = startLen;
        isWr  = (cyc == 4'h2);
        valid = (cyc == 4'h0) || isWr;
        hit   = (addr[15:8] == 8'h08);
        for (int k = 0; k < s; k++) begin
            ph.push_back(P_START);
            nib.push_back(5'b0_0000);
        end
        nib.push_back({1'b1, cyc});
        if (!valid) begin
            ph.push_back(P_IDLE);
        end else begin
            ph.push_back(P_ADR3); ph.push_back(P_ADR2); ph.push_back(P_ADR1); ph.push_back(P_ADR0);
            nib.push_back({1'b1, addr[15:12]}); nib.push_back({1'b1, addr[11:8]});
            nib.push_back({1'b1, addr[7:4]});   nib.push_back({1'b1, addr[3:0]});
            if (!hit) begin
                ph.push_back(P_IDLE);
            end else if (isWr) begin
                ph.push_back(P_WDL); ph.push_back(P_WDH); ph.push_back(P_HTAR0); ph.push_back(P_HTAR1);
                ph.push_back(P_SYNC); ph.push_back(P_PTAR0); ph.push_back(P_PTAR1); ph.push_back(P_IDLE);
                nib.push_back({1'b1, data[3:0]}); nib.push_back({1'b1, data[7:4]});
            end else begin
                ph.push_back(P_HTAR0); ph.push_back(P_HTAR1);
`ifdef LPC_SYNC_WAIT_EN
                ph.push_back(P_SWAIT);
`endif
                ph.push_back(P_SYNC); ph.push_back(P_RDL); ph.push_back(P_RDH);
                ph.push_back(P_PTAR0); ph.push_back(P_PTAR1); ph.push_back(P_IDLE);
            end
        end
        while (nib.size() < ph.size()) nib.push_back(5'b1_1111);
        abortIdx = -1;
        if (abortAt >= s && abortAt < ph.size()) begin
            abortIdx      = abortAt;
            nib[abortIdx] = {1'b0, abortLad};
            ph[abortIdx]  = (abortLad == 4'h0) ? P_START : P_IDLE;
            while (ph.size() > abortIdx + 1) begin
                void'(ph.pop_back());
                void'(nib.pop_back());
            end
        end
        n = (stopAt >= 0 && stopAt < ph.size()) ? stopAt : ph.size();
        for (int i = 0; i < n; i++) begin
            @(negedge LpcClock);
            LFRAME_n = nib[i][4];
            LAD      = nib[i][3:0];
            @(posedge LpcClock);
            #1;
            live = (abortIdx < 0) || (i < abortIdx);
            if (live && valid) begin
                if (i == s) mdlOpcode = isWr;
                if (i == s + 4 && hit) mdlAddr = addr[7:0];
                if (hit && isWr && i == s + 5) mdlWrData[3:0] = data[3:0];
                if (hit && isWr && i == s + 6) mdlWrData[7:4] = data[7:4];
            end
            expState = 16'h1 << ph[i];
            expHit   = (i >= s + 4) && (ph[i] != P_IDLE) && (ph[i] != P_START);
            expWr    = isWr && (ph[i] == P_SYNC);
            expRd    = !isWr && (ph[i] == P_HTAR0);
            assertCount++;
            if (State !== expState) begin
                failCount++;
                $display("[TB] FAIL %s state clk%0d: got %h expected %h", tag, i, State, expState);
            end
            assertCount++;
            if (Hit !== expHit) begin
                failCount++;
                $display("[TB] FAIL %s hit clk%0d: got %b expected %b", tag, i, Hit, expHit);
            end
            assertCount++;
            if (WrStb !== expWr) begin
                failCount++;
                $display("[TB] FAIL %s wrstb clk%0d: got %b expected %b", tag, i, WrStb, expWr);
            end
            assertCount++;
            if (RdStb !== expRd) begin
                failCount++;
                $display("[TB] FAIL %s rdstb clk%0d: got %b expected %b", tag, i, RdStb, expRd);
            end
            assertCount++;
            if ({Opcode, AddrReg, WrData} !== {mdlOpcode, mdlAddr, mdlWrData}) begin
                failCount++;
                $display("[TB] FAIL %s regs clk%0d: got op=%b addr=%h wd=%h expected op=%b addr=%h wd=%h",
                         tag, i, Opcode, AddrReg, WrData, mdlOpcode, mdlAddr, mdlWrData);
            end
        end
        endedInStart = (ph[n-1] == P_START);
    endtask

    task automatic test_reset();
        PciReset  = 1'b0;
        LFRAME_n  = 1'b1;
        LAD       = 4'hF;
        mdlOpcode = 1'b0;
        mdlAddr   = 8'h00;
        mdlWrData = 8'h00;
        repeat (2) @(posedge LpcClock);
        #1;
        assertCount++;
        if ({State, Opcode, AddrReg, Hit, WrData, WrStb, RdStb} !== {16'h0001, 1'b0, 8'h00, 1'b0, 8'h00, 2'b00}) begin
            failCount++;
            $display("[TB] FAIL reset_values: got state=%h op=%b addr=%h hit=%b wd=%h ws=%b rs=%b expected 0001/0/00/0/00/0/0",
                     State, Opcode, AddrReg, Hit, WrData, WrStb, RdStb);
        end
        @(negedge LpcClock);
        PciReset = 1'b1;
        @(posedge LpcClock);
        #1;
        assertCount++;
        if (State !== 16'h0001) begin
            failCount++;
            $display("[TB] FAIL reset_idle_hold: got %h expected 0001", State);
        end
    endtask

    task automatic test_io_write();
        runTxn(4'h2, 16'h0812, 8'hA5, 1, -1, 4'h0, -1, "io_write");
        assertCount++;
        if ({WrData, AddrReg, Opcode} !== {8'hA5, 8'h12, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL io_write_result: got wd=%h addr=%h op=%b expected A5/12/1", WrData, AddrReg, Opcode);
        end
    endtask

    task automatic test_io_read();
        runTxn(4'h0, 16'h08FF, 8'h00, 1, -1, 4'h0, -1, "io_read");
        assertCount++;
        if ({AddrReg, Opcode} !== {8'hFF, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL io_read_result: got addr=%h op=%b expected FF/0", AddrReg, Opcode);
        end
    endtask

    task automatic test_write_miss();
        runTxn(4'h2, 16'h0912, 8'h5A, 1, -1, 4'h0, -1, "write_miss");
        assertCount++;
        if ({AddrReg, WrData, Hit} !== {8'hFF, 8'hA5, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL write_miss_result: got addr=%h wd=%h hit=%b expected FF/A5/0", AddrReg, WrData, Hit);
        end
    endtask

    task automatic test_bad_cyctype();
        runTxn(4'h4, 16'h0800, 8'h00, 1, -1, 4'h0, -1, "mem_read");
        assertCount++;
        if (Opcode !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL mem_read_opcode: got %b expected 1", Opcode);
        end
    endtask

    task automatic test_abort();
        runTxn(4'h2, 16'h0840, 8'h77, 1, 7, 4'h0, -1, "abort_wdh");
        runTxn(4'h0, 16'h0834, 8'h00, 0, -1, 4'h0, -1, "read_after_abort");
        runTxn(4'h0, 16'h0856, 8'h00, 1, 7, 4'hF, -1, "abort_htar1");
    endtask

    task automatic test_back_to_back();
        runTxn(4'h2, 16'h08C3, 8'h3C, 1, 12, 4'h0, -1, "b2b_write");
        runTxn(4'h0, 16'h0801, 8'h00, 0, -1, 4'h0, -1, "b2b_read");
    endtask

    task automatic test_start_hold();
        runTxn(4'h0, 16'h0888, 8'h00, 3, -1, 4'h0, -1, "start_hold");
    endtask

    task automatic test_reset_mid();
        runTxn(4'h2, 16'h0822, 8'h99, 1, -1, 4'h0, 10, "reset_mid");
        #5;
        PciReset = 1'b0;
        #1;
        assertCount++;
        if ({State, Opcode, AddrReg, Hit, WrData, WrStb, RdStb} !== {16'h0001, 1'b0, 8'h00, 1'b0, 8'h00, 2'b00}) begin
            failCount++;
            $display("[TB] FAIL reset_mid_values: got state=%h op=%b addr=%h hit=%b wd=%h ws=%b rs=%b expected 0001/0/00/0/00/0/0",
                     State, Opcode, AddrReg, Hit, WrData, WrStb, RdStb);
        end
        mdlOpcode = 1'b0;
        mdlAddr   = 8'h00;
        mdlWrData = 8'h00;
        @(negedge LpcClock);
        PciReset = 1'b1;
        LFRAME_n = 1'b1;
        LAD      = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(posedge LpcClock);
            #1;
            assertCount++;
            if ({State, WrStb, RdStb} !== {16'h0001, 2'b00}) begin
                failCount++;
                $display("[TB] FAIL reset_mid_after clk%0d: got state=%h ws=%b rs=%b expected 0001/0/0", k, State, WrStb, RdStb);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  cyc;
        logic [15:0] addr;
        logic [3:0]  lad;
        int          sel;
        int          abortAt;
        int          gap;
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      cyc = 4'h2;
            else if (sel < 8) cyc = 4'h0;
            else if (sel == 8) cyc = 4'h1;
            else              cyc = 4'($urandom_range(3, 15));
            if ($urandom_range(0, 9) < 7) addr = {8'h08, 8'($urandom)};
            else                          addr = 16'($urandom);
            abortAt = -1;
            lad     = 4'h0;
            if ($urandom_range(0, 3) == 0) begin
                abortAt = $urandom_range(1, 15);
                lad     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            runTxn(cyc, addr, 8'($urandom), $urandom_range(1, 3), abortAt, lad, -1, "random");
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                @(negedge LpcClock);
                LFRAME_n = 1'b1;
                LAD      = 4'hF;
                @(posedge LpcClock);
                #1;
                assertCount++;
                if ({State, Hit, WrStb, RdStb} !== {16'h0001, 3'b000}) begin
                    failCount++;
                    $display("[TB] FAIL random_gap t%0d: got state=%h hit=%b ws=%b rs=%b expected 0001/0/0/0",
                             t, State, Hit, WrStb, RdStb);
                end
            end
        end
    endtask

    initial begin
        endedInStart = 1'b0;
        test_reset();
        test_io_write();
        test_io_read();
        test_write_miss();
        test_bad_cyctype();
        test_abort();
        test_back_to_back();
        test_start_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
